// File: rtl/oc8051_symbolic_cxrom_cache_if.sv
// Code-fetch/probe bundle between the 8051 core side and the symbolic code-ROM capture cache.
interface oc8051_symbolic_cxrom_cache_if #(
  parameter int unsigned AW          = 4,
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned NUM_PC      = 2
);
  logic                      fetch_en;
  logic                      flush;
  logic                      mismatch_clr;
  logic [15:0]               cxrom_addr;
  logic [8*FETCH_BYTES-1:0]  word_in;
  logic [8*FETCH_BYTES-1:0]  cxrom_data_out;
  logic [16*NUM_PC-1:0]      pc_in;
  logic                      op_valid;
  logic [7:0]                op_out;
  logic [AW:0]               fill_count;
  logic                      all_valid;
  logic                      mismatch;

  modport master (
    output fetch_en, flush, mismatch_clr, cxrom_addr, word_in, pc_in,
    input  cxrom_data_out, op_valid, op_out, fill_count, all_valid, mismatch
  );

  modport slave (
    input  fetch_en, flush, mismatch_clr, cxrom_addr, word_in, pc_in,
    output cxrom_data_out, op_valid, op_out, fill_count, all_valid, mismatch
  );
endinterface

// File: rtl/oc8051_symbolic_cxrom_cache.sv
// Write-once code-ROM capture cache: first fetch of each byte index latches it, later fetches reuse it.
// Optional CXROM_TAG_EN stores the upper address bits per entry so aliased addresses do not hit.
module oc8051_symbolic_cxrom_cache #(
  parameter int unsigned AW          = 4,
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned NUM_PC      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  oc8051_symbolic_cxrom_cache_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [7:0]             mem_q [DEPTH];
  logic [AW:0]            fill_count_q, fill_count_d;
  logic                   mismatch_q, mismatch_d;

  logic [15:0]            fetch_addr [FETCH_BYTES];
  logic [AW-1:0]          fetch_idx  [FETCH_BYTES];
  logic [FETCH_BYTES-1:0] hit, fill, diff;
  logic [AW:0]            fill_add;

  logic [15:0]            pc_addr [NUM_PC][FETCH_BYTES];
  logic [NUM_PC-1:0]      win_ok;
  logic                   pc0_hit;

`ifdef CXROM_TAG_EN
  logic [15-AW:0]         tag_q [DEPTH];
`endif

  always_comb begin
    fill_add = '0;
    for (int k = 0; k < FETCH_BYTES; k++) begin
      fetch_addr[k] = bus.cxrom_addr + 16'(k);
      fetch_idx[k]  = fetch_addr[k][AW-1:0];
`ifdef CXROM_TAG_EN
      hit[k] = valid_q[fetch_idx[k]] && (tag_q[fetch_idx[k]] == fetch_addr[k][15:AW]);
`else
      hit[k] = valid_q[fetch_idx[k]];
`endif
      bus.cxrom_data_out[8*k +: 8] = hit[k] ? mem_q[fetch_idx[k]] : bus.word_in[8*k +: 8];
      fill[k] = bus.fetch_en && !bus.flush && !valid_q[fetch_idx[k]];
      // A valid entry that misses (alias) counts as an inconsistency too.
      diff[k] = valid_q[fetch_idx[k]] &&
                (!hit[k] || (mem_q[fetch_idx[k]] != bus.word_in[8*k +: 8]));
      fill_add = fill_add + (AW+1)'(fill[k]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < FETCH_BYTES; k++) begin
      if (fill[k]) valid_d[fetch_idx[k]] = 1'b1;
    end
    fill_count_d = fill_count_q + fill_add;
    if (bus.flush) begin
      valid_d      = '0;
      fill_count_d = '0;
    end
    mismatch_d = (bus.fetch_en && (|diff)) || (mismatch_q && !bus.mismatch_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      fill_count_q <= '0;
      mismatch_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      fill_count_q <= fill_count_d;
      mismatch_q   <= mismatch_d;
    end
  end

  // Byte storage is deliberately unreset; validity alone gates its use.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_BYTES; k++) begin
      if (fill[k]) begin
        mem_q[fetch_idx[k]] <= bus.word_in[8*k +: 8];
`ifdef CXROM_TAG_EN
        tag_q[fetch_idx[k]] <= fetch_addr[k][15:AW];
`endif
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PC; j++) begin
      win_ok[j] = 1'b1;
      for (int k = 0; k < FETCH_BYTES; k++) begin
        pc_addr[j][k] = bus.pc_in[16*j +: 16] + 16'(k);
`ifdef CXROM_TAG_EN
        if (!(valid_q[pc_addr[j][k][AW-1:0]] &&
              (tag_q[pc_addr[j][k][AW-1:0]] == pc_addr[j][k][15:AW]))) begin
          win_ok[j] = 1'b0;
        end
`else
        if (!valid_q[pc_addr[j][k][AW-1:0]]) win_ok[j] = 1'b0;
`endif
      end
    end
`ifdef CXROM_TAG_EN
    pc0_hit = valid_q[bus.pc_in[AW-1:0]] && (tag_q[bus.pc_in[AW-1:0]] == bus.pc_in[15:AW]);
`else
    pc0_hit = valid_q[bus.pc_in[AW-1:0]];
`endif
  end

  assign bus.op_valid   = &win_ok;
  assign bus.op_out     = pc0_hit ? mem_q[bus.pc_in[AW-1:0]] : 8'h00;
  assign bus.fill_count = fill_count_q;
  assign bus.all_valid  = (fill_count_q == (AW+1)'(DEPTH));
  assign bus.mismatch   = mismatch_q;
endmodule

// File: tb/tb_oc8051_symbolic_cxrom_cache.sv
// Directed bench for the code-ROM capture cache (AW=4, FETCH_BYTES=4, NUM_PC=2).
module tb_oc8051_symbolic_cxrom_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  oc8051_symbolic_cxrom_cache_if #(.AW(4), .FETCH_BYTES(4), .NUM_PC(2)) bus ();

  oc8051_symbolic_cxrom_cache #(.AW(4), .FETCH_BYTES(4), .NUM_PC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_en     = 1'b0;
    bus.flush        = 1'b0;
    bus.mismatch_clr = 1'b0;
    bus.cxrom_addr   = 16'h0000;
    bus.word_in      = 32'h0000_0000;
    bus.pc_in        = 32'h0000_0000;
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
  endtask

  task automatic fetch(input logic [15:0] a, input logic [31:0] w);
    bus.fetch_en   = 1'b1;
    bus.cxrom_addr = a;
    bus.word_in    = w;
    step();
    bus.fetch_en   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.word_in = 32'h1234_5678;
    bus.pc_in   = 32'h0000_0000;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'h1234_5678) $display("FAIL rst_data got %h want %h", bus.cxrom_data_out, 32'h1234_5678); else pass_cnt++;
    total_cnt++; if (bus.op_valid !== 1'b0) $display("FAIL rst_op_valid got %b want 0", bus.op_valid); else pass_cnt++;
    total_cnt++; if (bus.op_out !== 8'h00) $display("FAIL rst_op_out got %h want 00", bus.op_out); else pass_cnt++;
    total_cnt++; if (bus.fill_count !== 5'd0) $display("FAIL rst_fill_count got %0d want 0", bus.fill_count); else pass_cnt++;
    total_cnt++; if (bus.all_valid !== 1'b0) $display("FAIL rst_all_valid got %b want 0", bus.all_valid); else pass_cnt++;
    total_cnt++; if (bus.mismatch !== 1'b0) $display("FAIL rst_mismatch got %b want 0", bus.mismatch); else pass_cnt++;
    #3 rst = 1'b1;
    step();
  endtask

  task automatic test_fill_consistency();
    do_reset();
    bus.fetch_en = 1'b1; bus.cxrom_addr = 16'h0000; bus.word_in = 32'h4433_2211;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'h4433_2211) $display("FAIL first_fetch_data got %h want %h", bus.cxrom_data_out, 32'h4433_2211); else pass_cnt++;
    step();
    total_cnt++; if (bus.fill_count !== 5'd4) $display("FAIL first_fill_count got %0d want 4", bus.fill_count); else pass_cnt++;
    total_cnt++; if (bus.mismatch !== 1'b0) $display("FAIL first_no_mismatch got %b want 0", bus.mismatch); else pass_cnt++;
    bus.word_in = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'h4433_2211) $display("FAIL refetch_data got %h want %h", bus.cxrom_data_out, 32'h4433_2211); else pass_cnt++;
    step();
    bus.fetch_en = 1'b0;
    total_cnt++; if (bus.mismatch !== 1'b1) $display("FAIL refetch_mismatch got %b want 1", bus.mismatch); else pass_cnt++;
    total_cnt++; if (bus.fill_count !== 5'd4) $display("FAIL refetch_no_count got %0d want 4", bus.fill_count); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    fetch(16'h000E, 32'hD4C3_B2A1);
    total_cnt++; if (bus.fill_count !== 5'd4) $display("FAIL wrap_fill_count got %0d want 4", bus.fill_count); else pass_cnt++;
    bus.pc_in = {16'h000E, 16'h000E};
    #1;
    total_cnt++; if (bus.op_valid !== 1'b1) $display("FAIL wrap_op_valid got %b want 1", bus.op_valid); else pass_cnt++;
    total_cnt++; if (bus.op_out !== 8'hA1) $display("FAIL wrap_op_out got %h want a1", bus.op_out); else pass_cnt++;
    bus.pc_in = {16'h000F, 16'h000E};
    #1;
    total_cnt++; if (bus.op_valid !== 1'b0) $display("FAIL wrap_win1_partial got %b want 0", bus.op_valid); else pass_cnt++;
    bus.pc_in = {16'h000E, 16'h0002};
    #1;
    total_cnt++; if (bus.op_out !== 8'h00) $display("FAIL wrap_op_out_invalid got %h want 00", bus.op_out); else pass_cnt++;
    bus.cxrom_addr = 16'h0000; bus.word_in = 32'hFFFF_FFFF;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'hFFFF_D4C3) $display("FAIL wrap_mixed_data got %h want %h", bus.cxrom_data_out, 32'hFFFF_D4C3); else pass_cnt++;
    step();
    total_cnt++; if (bus.fill_count !== 5'd4) $display("FAIL wrap_idle_no_fill got %0d want 4", bus.fill_count); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    fetch(16'h0000, 32'h0302_0100);
    fetch(16'h0004, 32'h0706_0504);
    fetch(16'h0008, 32'h0B0A_0908);
    total_cnt++; if (bus.all_valid !== 1'b0) $display("FAIL flush_partial_all_valid got %b want 0", bus.all_valid); else pass_cnt++;
    fetch(16'h000C, 32'h0F0E_0D0C);
    total_cnt++; if (bus.fill_count !== 5'd16) $display("FAIL full_fill_count got %0d want 16", bus.fill_count); else pass_cnt++;
    total_cnt++; if (bus.all_valid !== 1'b1) $display("FAIL full_all_valid got %b want 1", bus.all_valid); else pass_cnt++;
    bus.pc_in = {16'h000C, 16'h0005};
    #1;
    total_cnt++; if (bus.op_valid !== 1'b1) $display("FAIL full_op_valid got %b want 1", bus.op_valid); else pass_cnt++;
    total_cnt++; if (bus.op_out !== 8'h05) $display("FAIL full_op_out got %h want 05", bus.op_out); else pass_cnt++;
    bus.flush = 1'b1;
    fetch(16'h0000, 32'hAAAA_AAAA);
    bus.flush = 1'b0;
    bus.pc_in = 32'h0000_0000;
    #1;
    total_cnt++; if (bus.fill_count !== 5'd0) $display("FAIL flush_fill_count got %0d want 0", bus.fill_count); else pass_cnt++;
    total_cnt++; if (bus.op_valid !== 1'b0) $display("FAIL flush_op_valid got %b want 0", bus.op_valid); else pass_cnt++;
    total_cnt++; if (bus.all_valid !== 1'b0) $display("FAIL flush_all_valid got %b want 0", bus.all_valid); else pass_cnt++;
    total_cnt++; if (bus.mismatch !== 1'b1) $display("FAIL flush_prevalid_mismatch got %b want 1", bus.mismatch); else pass_cnt++;
    bus.cxrom_addr = 16'h0000; bus.word_in = 32'h5566_7788;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'h5566_7788) $display("FAIL flush_passthru got %h want %h", bus.cxrom_data_out, 32'h5566_7788); else pass_cnt++;
    fetch(16'h0000, 32'h5566_7788);
    bus.word_in = 32'h0000_0000;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'h5566_7788) $display("FAIL flush_refill_data got %h want %h", bus.cxrom_data_out, 32'h5566_7788); else pass_cnt++;
    total_cnt++; if (bus.fill_count !== 5'd4) $display("FAIL flush_refill_count got %0d want 4", bus.fill_count); else pass_cnt++;
  endtask

  task automatic test_mismatch_clr();
    do_reset();
    fetch(16'h0000, 32'h1111_1111);
    fetch(16'h0000, 32'h1111_1111);
    total_cnt++; if (bus.mismatch !== 1'b0) $display("FAIL match_no_set got %b want 0", bus.mismatch); else pass_cnt++;
    fetch(16'h0000, 32'h2222_2222);
    total_cnt++; if (bus.mismatch !== 1'b1) $display("FAIL mm_set got %b want 1", bus.mismatch); else pass_cnt++;
    bus.mismatch_clr = 1'b1;
    fetch(16'h0000, 32'h3333_3333);
    total_cnt++; if (bus.mismatch !== 1'b1) $display("FAIL mm_set_wins got %b want 1", bus.mismatch); else pass_cnt++;
    step();
    bus.mismatch_clr = 1'b0;
    total_cnt++; if (bus.mismatch !== 1'b0) $display("FAIL mm_clear got %b want 0", bus.mismatch); else pass_cnt++;
    bus.word_in = 32'h9999_9999;
    step();
    total_cnt++; if (bus.mismatch !== 1'b0) $display("FAIL mm_no_fetch_no_set got %b want 0", bus.mismatch); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch(16'h0000, 32'h0102_0304);
    fetch(16'h0000, 32'h0000_0000);
    bus.pc_in = 32'h0000_0000;
    #1;
    total_cnt++; if (bus.op_valid !== 1'b1) $display("FAIL pre_arst_op_valid got %b want 1", bus.op_valid); else pass_cnt++;
    #2 rst = 1'b0;
    bus.word_in = 32'hCAFE_F00D;
    #1;
    total_cnt++; if (bus.op_valid !== 1'b0) $display("FAIL arst_op_valid got %b want 0", bus.op_valid); else pass_cnt++;
    total_cnt++; if (bus.fill_count !== 5'd0) $display("FAIL arst_fill_count got %0d want 0", bus.fill_count); else pass_cnt++;
    total_cnt++; if (bus.mismatch !== 1'b0) $display("FAIL arst_mismatch got %b want 0", bus.mismatch); else pass_cnt++;
    total_cnt++; if (bus.cxrom_data_out !== 32'hCAFE_F00D) $display("FAIL arst_data got %h want %h", bus.cxrom_data_out, 32'hCAFE_F00D); else pass_cnt++;
    #1 rst = 1'b1;
    step();
    fetch(16'h0000, 32'hA0B0_C0D0);
    bus.word_in = 32'h0000_0000;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'hA0B0_C0D0) $display("FAIL arst_relatch got %h want %h", bus.cxrom_data_out, 32'hA0B0_C0D0); else pass_cnt++;
    total_cnt++; if (bus.mismatch !== 1'b0) $display("FAIL arst_relatch_mm got %b want 0", bus.mismatch); else pass_cnt++;
  endtask

  task automatic test_alias();
    do_reset();
    fetch(16'h0000, 32'h4433_2211);
    bus.fetch_en = 1'b1; bus.cxrom_addr = 16'h0010; bus.word_in = 32'h8877_6655;
    #1;
`ifdef CXROM_TAG_EN
    total_cnt++; if (bus.cxrom_data_out !== 32'h8877_6655) $display("FAIL alias_tag_data got %h want %h", bus.cxrom_data_out, 32'h8877_6655); else pass_cnt++;
`else
    total_cnt++; if (bus.cxrom_data_out !== 32'h4433_2211) $display("FAIL alias_shared_data got %h want %h", bus.cxrom_data_out, 32'h4433_2211); else pass_cnt++;
`endif
    step();
    bus.fetch_en = 1'b0;
    total_cnt++; if (bus.mismatch !== 1'b1) $display("FAIL alias_mismatch got %b want 1", bus.mismatch); else pass_cnt++;
    total_cnt++; if (bus.fill_count !== 5'd4) $display("FAIL alias_no_overwrite_count got %0d want 4", bus.fill_count); else pass_cnt++;
    bus.cxrom_addr = 16'h0000; bus.word_in = 32'h0000_0000;
    #1;
    total_cnt++; if (bus.cxrom_data_out !== 32'h4433_2211) $display("FAIL alias_orig_kept got %h want %h", bus.cxrom_data_out, 32'h4433_2211); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_consistency();
    test_wrap();
    test_flush();
    test_mismatch_clr();
    test_async_reset();
    test_alias();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/oc8051_symbolic_cxrom_cache.md
Name: oc8051_symbolic_cxrom_cache

Overview:
Parametrised write-once code-ROM capture cache for symbolic verification of the 8051 core.
- The first fetch of each ROM byte index latches that byte; later fetches of the same index are served from the latched copy, so the ROM stays consistent across the run.
- Depth, fetch width and number of probed PCs are generic.
- Adds fill qualification, flush, fill counting and a sticky consistency-mismatch flag.
- Sits between the core's code-fetch port and the ROM model.

Parameters:
AW, 4, log2 of entry count; DEPTH = 2^AW bytes.
FETCH_BYTES, 4, bytes per fetch word; must be <= DEPTH.
NUM_PC, 2, number of PC probe ports that must all be fully cached for op_valid.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
fetch_en  in  1  qualifies cxrom_addr/word_in as a real fetch this cycle
flush  in  1  synchronous clear of all valid bits and fill_count
mismatch_clr  in  1  clears sticky mismatch
cxrom_addr  in  16  byte address of fetch word
word_in  in  8*FETCH_BYTES  raw ROM data, byte k at bits [8k+7:8k]
cxrom_data_out  out  8*FETCH_BYTES  consistent fetch data to core
pc_in  in  16*NUM_PC  probe PCs, PC j at bits [16j+15:16j]
op_valid  out  1  every probe window fully cached
op_out  out  8  cached byte at PC0
fill_count  out  AW+1  number of valid entries
all_valid  out  1  fill_count == DEPTH
mismatch  out  1  sticky: fetched data disagreed with latched byte

Behaviour:
- Index of byte k of a fetch = (cxrom_addr[AW-1:0] + k) mod DEPTH. Wrap-around is silent. The indices in one window are distinct because FETCH_BYTES <= DEPTH.
- Reset (rst=0, async): valid bits, fill_count and mismatch cleared. Byte array is not reset.
  - While reset is held: op_valid=0, op_out=0, all_valid=0, cxrom_data_out=word_in.
- cxrom_data_out byte k, combinational, zero latency: latched byte if index valid, else word_in byte k. This holds regardless of fetch_en.
- Fill: on a clock edge with fetch_en=1 and flush=0, each byte k whose index is invalid is written with word_in byte k and its valid bit is set. Valid bytes are never overwritten.
- fill_count: registered. Increments by the number of bytes newly filled that edge (0..FETCH_BYTES). Never exceeds DEPTH.
- Mismatch: on an edge with fetch_en=1, mismatch sets if any byte whose index was already valid before the edge differs from word_in.
  - mismatch_clr=1 clears it.
  - Same-edge set and clear: set wins.
  - flush does not affect mismatch.
- flush=1: all valid bits and fill_count go to 0 on the edge. flush has priority over a same-cycle fill, so nothing is written that edge. Mismatch detection still uses pre-flush valid state.
- Probes: window j is valid when all FETCH_BYTES indices starting at pc_in[j][AW-1:0] (mod DEPTH) are valid.
  - op_valid = AND of all windows. Combinational off registered state.
  - op_out = byte at pc_in[0] index if that index is valid, else 8'h00.
- all_valid = (fill_count == DEPTH).
- fetch_en=0: no writes, no count change, no mismatch update. Outputs are still driven.

Optional Feature:
CXROM_TAG_EN
- Defined:
  - Each entry also stores tag = upper 16-AW bits of its full 16-bit byte address ((cxrom_addr + k) truncated to 16 bits). The tag is written on fill.
  - An index counts as a hit only if valid and the stored tag equals the requesting address tag. This applies to data_out selection, mismatch compare and probe validity.
  - A valid entry with a different tag: data_out passes word_in, no overwrite, and mismatch sets (aliasing is treated as an inconsistency).
- Undefined: no tag storage. Addresses aliasing mod DEPTH share entries, and the tag check is absent.

Test Plan:
1. Reset, fetch_en=1, addr=16'h0000, word=32'h44332211 -> data_out=32'h44332211; next cycle fill_count=4. Refetch with word=32'hDEADBEEF -> data_out=32'h44332211, mismatch=1 after edge.
2. Wrap-around, AW=4: addr=16'h000E, word=32'hD4C3B2A1 -> indices 14,15,0,1 filled; fill_count=4. pc_in={16'h000E,16'h000E} -> op_valid=1, op_out=8'hA1.
3. Fill all 16 bytes via addrs 0,4,8,12 -> all_valid=1, fill_count=16. Assert flush together with a fetch -> next cycle fill_count=0, op_valid=0, no byte written.
4. mismatch set, then mismatch_clr=1 with a new mismatching fetch in the same cycle -> mismatch stays 1. Clear alone -> mismatch=0.
5. Drive rst=0 asynchronously mid-fill (between edges) -> op_valid, fill_count and mismatch are 0 immediately. After release, a refetch of addr 0 with new data is latched as new.
6. With CXROM_TAG_EN: fill addr 16'h0000, then fetch addr 16'h0010 -> data_out=word_in and mismatch=1. Without the macro -> data_out=the latched bytes from addr 0.
